chipset_decoder: RTL

CHIPSET_DECODER -- requirements
Module: chipset_decoder

---
 rtl/chipset_decoder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/chipset_decoder.sv
// chipset_decoder: address decoder with per-region wait states.
// An access is accepted in IDLE, spends WAIT[hit]+1 cycles in WAIT
// (skipped for unmapped addresses) and completes in a single RESP cycle.
// All outputs come straight from flops.
module chipset_decoder #(
  parameter int                     ADDR_W = 11,
  parameter int                     DATA_W = 32,
  parameter int                     NREG   = 2,
  parameter logic [NREG*ADDR_W-1:0] BASE   = {11'h080, 11'h000},
  parameter logic [NREG*ADDR_W-1:0] LIMIT  = {11'h7FF, 11'h07F},
  parameter logic [NREG*4-1:0]      WAIT   = {4'd2, 4'd0}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [NREG*DATA_W-1:0] rd_bus,
  output logic [NREG-1:0]        sel,
  output logic [NREG-1:0]        wen,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ready,
  output logic                   err,
  output logic [7:0]             err_count
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   hit_q, hit_d;
  logic [NREG-1:0]    sel_q, sel_d;
  logic [NREG-1:0]    wen_q, wen_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic [7:0]         err_count_q, err_count_d;

  logic               hit_any_s;
  logic [IDX_W-1:0]   hit_idx_s;
  logic [3:0]         wait_s;
  logic [NREG-1:0]    onehot_s;
  logic [DATA_W-1:0]  rd_sel_s;

  // Saturating increment for the unmapped-access counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // Address decode; scanning downwards lets the lowest matching region win.
  always_comb begin
    hit_any_s = 1'b0;
    hit_idx_s = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if ((addr >= BASE[i*ADDR_W +: ADDR_W]) && (addr <= LIMIT[i*ADDR_W +: ADDR_W])) begin
        hit_any_s = 1'b1;
        hit_idx_s = IDX_W'(i);
      end else begin
        hit_any_s = hit_any_s;
      end
    end
  end

  // Per-region lookups: wait count and one-hot for the live decode,
  // read-data slice for the latched region.
  always_comb begin
    wait_s   = 4'd0;
    onehot_s = '0;
    rd_sel_s = '0;
    for (int i = 0; i < NREG; i++) begin
      if (hit_idx_s == IDX_W'(i)) begin
        wait_s      = WAIT[i*4 +: 4];
        onehot_s[i] = 1'b1;
      end else begin
        onehot_s[i] = 1'b0;
      end
      if (hit_q == IDX_W'(i)) begin
        rd_sel_s = rd_bus[i*DATA_W +: DATA_W];
      end else begin
        rd_sel_s = rd_sel_s;
      end
    end
  end

  // Next-state and next-output logic of the access FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    hit_d       = hit_q;
    sel_d       = sel_q;
    wen_d       = '0;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        if (req) begin
          we_d = we;
          if (hit_any_s) begin
            hit_d   = hit_idx_s;
            cnt_d   = wait_s;
            sel_d   = onehot_s;
            state_d = ST_WAIT;
          end else begin
            // Unmapped: straight to RESP with the error flag, no select.
            cnt_d       = 4'd0;
            ready_d     = 1'b1;
            err_d       = 1'b1;
            err_count_d = sat_inc(err_count_q);
            state_d     = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          ready_d = 1'b1;
          state_d = ST_RESP;
          if (we_q) begin
            wen_d = sel_q;
          end else begin
            rdata_d = rd_sel_s;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        sel_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        sel_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      hit_q       <= '0;
      sel_q       <= '0;
      wen_q       <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      hit_q       <= hit_d;
      sel_q       <= sel_d;
      wen_q       <= wen_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign sel       = sel_q;
  assign wen       = wen_q;
  assign rdata     = rdata_q;
  assign ready     = ready_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule
